lr3_sbox_round_ctrl: RTL
========================

# lr3_sbox_round_ctrl

Multi-cycle controller that runs a 4·NIB-bit word through ROUNDS rounds of nibble substitution and nibble rotation. It owns a single shared 4-bit substitution LUT and applies it to one nibble per clock. The block sits between an upstream valid/ready source and a downstream valid/ready sink in the LR3 sequential-logic datapath.

## Interface
- NIB, default 4: nibbles per word. Word width W = 4·NIB. Legal range NIB ≥ 2.
- ROUNDS, default 2: substitution+rotation rounds per word. Legal range ROUNDS ≥ 1.
- CLK  in  1  single clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  upstream word present.
- IN_READY  out  1  block can accept a word.
- IN_DATA  in  W  input word.
- OUT_VALID  out  1  result present.
- OUT_READY  in  1  downstream accepts the result.
- OUT_DATA  out  W  result word.
- BUSY  out  1  high whenever state ≠ IDLE.

## Operation
- Substitution S(x), hex in→out: 0→2, 1→2, 2→A, 3→1, 4→C, 5→6, 6→0, 7→5, 8→F, 9→C, A→4, B→B, C→A, D→9, E→5, F→5.
- Working register WORD (W bits), nibble index NI (width max(1, clog2 NIB)), round counter RC (width max(1, clog2 ROUNDS)).
- FSM states:
  - IDLE: IN_READY=1. On IN_VALID·IN_READY: WORD←IN_DATA, NI←0, RC←0, go to SUB.
  - SUB: WORD[4·NI+3 : 4·NI]←S(that nibble). NI←NI+1. When NI=NIB-1, NI←0 and go to ROT.
  - ROT: WORD←rotate-left by 4 bits, so bits [W-1:W-4] move to [3:0]. If RC=ROUNDS-1, go to DONE. Otherwise RC←RC+1 and go to SUB.
  - DONE: OUT_VALID=1 and OUT_DATA=WORD. On OUT_READY, go to IDLE. While OUT_READY=0, hold. WORD and OUT_DATA must stay stable.
- Nibble 0 is bits [3:0] and is processed first.
- Only one LUT instance is used. Its input is the nibble at NI, selected by a mux.
- IN_READY is high only in IDLE, so words never overlap. IN_DATA is ignored in every other state.
- OUT_DATA is driven from WORD continuously. It is only meaningful while OUT_VALID=1.

## Timing
- Reset values: state=IDLE, WORD=0, NI=0, RC=0, IN_READY=1 (IDLE), OUT_VALID=0, OUT_DATA=0, BUSY=0.
- RST has priority over every other input. Reset during SUB, ROT or DONE discards the in-flight word. The next cycle is IDLE with the reset values above, and no OUT_VALID pulse occurs.
- Latency: accept edge to first cycle with OUT_VALID=1 is ROUNDS·(NIB+1) edges. With the defaults this is 10.
- Handshakes complete on rising edges where valid and ready are both high.
- DONE with OUT_READY=1: the next state is IDLE. IN_READY is low in the DONE cycle, which gives a mandatory one-cycle bubble.
- Back-to-back throughput: one word per ROUNDS·(NIB+1)+2 cycles when OUT_READY is tied high.
- IN_VALID may drop or change while IN_READY=0 without effect.
- OUT_READY asserted outside DONE has no effect.
- Counter wrap: NI and RC never exceed NIB-1 and ROUNDS-1 respectively. When ROUNDS=1, RC stays 0.

## Structure
- Shared package/header lr3_pkg holds:
  - the FSM state encoding constants (IDLE, SUB, ROT, DONE; 2 bits);
  - the 16-entry S-box constant table.
- Sub-module lr3_nibble_sbox: a purely combinational 4-bit in, 4-bit out LUT built from the package table. It is instantiated once.
- All registers, the FSM, the nibble mux, the rotate logic and the handshake logic live in lr3_sbox_round_ctrl.

## Test plan
- Reset: hold RST 3 cycles → IN_READY=1, OUT_VALID=0, BUSY=0, OUT_DATA=0x0000.
- Single word, default parameters, IN_DATA=0x0123, OUT_READY=1 → OUT_VALID rises 10 edges after accept, OUT_DATA=0x42AA. With ROUNDS=1, OUT_DATA=0x2A12 after 5 edges.
- Corner values, default parameters:
  - 0xFFFF → 0x6666.
  - 0x0000 → 0xAAAA.
  - Check that BUSY is high for every cycle from accept until the output handshake.
- Backpressure: OUT_READY=0 for 7 cycles in DONE → OUT_VALID stays high and OUT_DATA stays at 0x42AA. IN_READY stays low. Raising OUT_READY gives IDLE on the next cycle.
- Reset mid-operation: assert RST 4 cycles after accepting 0x0123 → next cycle is IDLE. No OUT_VALID is seen. A following word 0xFFFF yields 0x6666 with normal latency.
- Back-to-back: IN_VALID held high with words 0x0123 then 0x0000 and OUT_READY=1 → second accept occurs 12 cycles after the first. Outputs are 0x42AA then 0xAAAA, in order, with no duplicates.

Source files
------------

// File: rtl/lr3_pkg.sv
// lr3_pkg: shared FSM state encoding and 4-bit substitution table
// for the LR3 nibble-substitution round controller.
`default_nettype none

package lr3_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_SUB  = 2'd1,
      ST_ROT  = 2'd2,
      ST_DONE = 2'd3
   } state_t;

   // Entry i of the S-box lives in bits [4i+3:4i].
   localparam logic [63:0] SBOX_TABLE = 64'h559A_B4CF_506C_1A22;

   function automatic logic [3:0] sbox_lookup(input logic [3:0] x);
      return SBOX_TABLE[{x, 2'b00} +: 4];
   endfunction

endpackage

`default_nettype wire

// File: rtl/lr3_nibble_sbox.sv
// lr3_nibble_sbox: purely combinational 4-bit substitution LUT.
`default_nettype none

module lr3_nibble_sbox
   import lr3_pkg::*;
(
   input  logic [3:0] nib_in,
   output logic [3:0] nib_out
);

   assign nib_out = sbox_lookup(nib_in);

endmodule

`default_nettype wire

// File: rtl/lr3_sbox_round_ctrl.sv
// lr3_sbox_round_ctrl: runs a word through ROUNDS rounds of per-nibble
// substitution (one nibble per clock, single shared LUT) and a 4-bit left rotation.
`default_nettype none

module lr3_sbox_round_ctrl
   import lr3_pkg::*;
#(
   parameter int NIB    = 4,
   parameter int ROUNDS = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [4*NIB-1:0]  in_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [4*NIB-1:0]  out_data,
   output logic              busy
);

   localparam int W    = 4 * NIB;
   localparam int NI_W = (NIB > 1) ? $clog2(NIB) : 1;
   localparam int RC_W = (ROUNDS > 1) ? $clog2(ROUNDS) : 1;
   localparam logic [NI_W-1:0] NI_LAST = NI_W'(NIB - 1);
   localparam logic [RC_W-1:0] RC_LAST = RC_W'(ROUNDS - 1);

   state_t          state, state_nxt;
   logic [W-1:0]    word, word_nxt, word_sub;
   logic [NI_W-1:0] ni, ni_nxt;
   logic [RC_W-1:0] rc, rc_nxt;
   logic [3:0]      sub_in, sub_out;

   lr3_nibble_sbox u_sbox (
      .nib_in  (sub_in),
      .nib_out (sub_out)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
         word  <= '0;
         ni    <= '0;
         rc    <= '0;
      end else begin
         state <= state_nxt;
         word  <= word_nxt;
         ni    <= ni_nxt;
         rc    <= rc_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      word_nxt  = word;
      ni_nxt    = ni;
      rc_nxt    = rc;
      // The single LUT sees whichever nibble NI points at.
      sub_in    = word[{ni, 2'b00} +: 4];
      word_sub  = word;
      word_sub[{ni, 2'b00} +: 4] = sub_out;

      case (state)
         ST_IDLE: begin
            if (in_valid) begin
               word_nxt  = in_data;
               ni_nxt    = '0;
               rc_nxt    = '0;
               state_nxt = ST_SUB;
            end
         end
         ST_SUB: begin
            word_nxt = word_sub;
            if (ni == NI_LAST) begin
               ni_nxt    = '0;
               state_nxt = ST_ROT;
            end else begin
               ni_nxt = ni + 1'b1;
            end
         end
         ST_ROT: begin
            word_nxt = {word[W-5:0], word[W-1:W-4]};
            if (rc == RC_LAST) begin
               state_nxt = ST_DONE;
            end else begin
               rc_nxt    = rc + 1'b1;
               state_nxt = ST_SUB;
            end
         end
         ST_DONE: begin
            if (out_ready) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign in_ready  = (state == ST_IDLE);
   assign out_valid = (state == ST_DONE);
   assign busy      = (state != ST_IDLE);
   assign out_data  = word;

endmodule

`default_nettype wire
